// File: rtl/alu_arbiter.sv
`timescale 1ns/1ps
// alu_arbiter: shares one combinational add/sub ALU between two requesters.
// One operation is in flight at a time; it walks IDLE -> EXEC -> RESP.
// Optional build macro: ALU_ARB_FIXED_PRIO_EN selects fixed priority
// (requester 0 wins contention). Without it, round-robin arbitration is used.
//
// Handshakes: a request transfers on a clock edge where req_valid[i] and
// req_ready[i] are both high; requesters keep valid and operands stable until
// then. A response transfers on an edge where rsp_valid[i] and rsp_ready[i]
// are both high; rsp_result/rsp_zero stay stable while rsp_valid is high.
module alu_arbiter #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        req_valid,
   output logic [1:0]        req_ready,
   input  logic [DATA_W-1:0] req0_src1,
   input  logic [DATA_W-1:0] req0_src2,
   input  logic              req0_sub,
   input  logic [DATA_W-1:0] req1_src1,
   input  logic [DATA_W-1:0] req1_src2,
   input  logic              req1_sub,
   output logic [1:0]        rsp_valid,
   input  logic [1:0]        rsp_ready,
   output logic [DATA_W-1:0] rsp_result,
   output logic              rsp_zero,
   output logic [DATA_W-1:0] alu_src1,
   output logic [DATA_W-1:0] alu_src2,
   output logic [1:0]        ALU_Op,
   output logic              add_sub_sel,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_zero,
   output logic [1:0]        dbg_state,
   output logic              dbg_last_grant
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_next_state;
   logic              w_gnt;
   logic              w_accept;
   logic              w_done;
   logic [DATA_W-1:0] r_op_src1;
   logic [DATA_W-1:0] r_op_src2;
   logic              r_op_sub;
   logic              r_op_gnt;
   logic              r_last_grant;
   logic [1:0]        r_rsp_valid;
   logic [DATA_W-1:0] r_rsp_result;
   logic              r_rsp_zero;

   // Grant selection: a lone requester always wins; contention is resolved by policy.
   always_comb begin
      w_gnt = 1'b0;
      if (req_valid == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
         w_gnt = 1'b0;
`else
         w_gnt = ~r_last_grant;
`endif
      end else if (req_valid == 2'b10) begin
         w_gnt = 1'b1;
      end
   end

   // Next-state and handshake strobes; req_ready only depends on state, req_valid, last grant.
   always_comb begin
      w_next_state = r_state;
      req_ready    = 2'b00;
      w_accept     = 1'b0;
      w_done       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (req_valid != 2'b00) begin
               req_ready[w_gnt] = 1'b1;
               w_accept         = 1'b1;
               w_next_state     = ST_EXEC;
            end
         end
         ST_EXEC: begin
            w_next_state = ST_RESP;
         end
         ST_RESP: begin
            // rsp_ready on the bit we are not serving is deliberately ignored.
            if (rsp_ready[r_op_gnt]) begin
               w_done       = 1'b1;
               w_next_state = ST_IDLE;
            end
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_next_state;
   end

   // Operand registers: capture the granted requester's operation on accept.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_op_src1 <= '0;
         r_op_src2 <= '0;
         r_op_sub  <= 1'b0;
         r_op_gnt  <= 1'b0;
      end else if (w_accept) begin
         r_op_src1 <= w_gnt ? req1_src1 : req0_src1;
         r_op_src2 <= w_gnt ? req1_src2 : req0_src2;
         r_op_sub  <= w_gnt ? req1_sub  : req0_sub;
         r_op_gnt  <= w_gnt;
      end
   end

   // Response registers: capture the ALU at the end of EXEC, clear valid on handshake.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rsp_valid  <= 2'b00;
         r_rsp_result <= '0;
         r_rsp_zero   <= 1'b0;
      end else if (r_state == ST_EXEC) begin
         r_rsp_valid  <= r_op_gnt ? 2'b10 : 2'b01;
         r_rsp_result <= alu_result;
         r_rsp_zero   <= alu_zero;
      end else if (w_done) begin
         r_rsp_valid  <= 2'b00;
      end
   end

   // Round-robin history: remember who was served last; requester 0 wins the first tie.
   always_ff @(posedge clk) begin
      if (reset)       r_last_grant <= 1'b1;
      else if (w_done) r_last_grant <= r_op_gnt;
   end

   assign alu_src1       = r_op_src1;
   assign alu_src2       = r_op_src2;
   assign add_sub_sel    = r_op_sub;
   assign ALU_Op         = 2'b00;
   assign rsp_valid      = r_rsp_valid;
   assign rsp_result     = r_rsp_result;
   assign rsp_zero       = r_rsp_zero;
   assign dbg_state      = r_state;
   assign dbg_last_grant = r_last_grant;

endmodule

// File: tb/tb_alu_arbiter.sv
`timescale 1ns/1ps
// tb_alu_arbiter: randomized and directed bench for alu_arbiter against a
// transaction-level reference model (one outstanding op, result due two cycles
// after acceptance, grant chosen from the arbitration rules).
module tb_alu_arbiter;

   localparam int DATA_W = 32;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [1:0]        req_valid = 2'b00;
   logic [1:0]        req_ready;
   logic [DATA_W-1:0] req0_src1 = '0, req0_src2 = '0, req1_src1 = '0, req1_src2 = '0;
   logic              req0_sub = 1'b0, req1_sub = 1'b0;
   logic [1:0]        rsp_valid;
   logic [1:0]        rsp_ready = 2'b00;
   logic [DATA_W-1:0] rsp_result;
   logic              rsp_zero;
   logic [DATA_W-1:0] alu_src1, alu_src2, alu_result;
   logic [1:0]        ALU_Op;
   logic              add_sub_sel, alu_zero;
   logic [1:0]        dbg_state;
   logic              dbg_last_grant;

   alu_arbiter #(.DATA_W(DATA_W)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req0_src1(req0_src1), .req0_src2(req0_src2), .req0_sub(req0_sub),
      .req1_src1(req1_src1), .req1_src2(req1_src2), .req1_sub(req1_sub),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_zero(rsp_zero),
      .alu_src1(alu_src1), .alu_src2(alu_src2), .ALU_Op(ALU_Op),
      .add_sub_sel(add_sub_sel), .alu_result(alu_result), .alu_zero(alu_zero),
      .dbg_state(dbg_state), .dbg_last_grant(dbg_last_grant)
   );

   // Combinational ALU stub; its zero flag is high when the operands differ.
   assign alu_result = add_sub_sel ? (alu_src1 - alu_src2) : (alu_src1 + alu_src2);
   assign alu_zero   = (alu_src1 != alu_src2);

   // Clock.
   always #5 clk = ~clk;

   // Requester-side pending operations.
   logic              p_vld [2];
   logic [DATA_W-1:0] p_s1  [2];
   logic [DATA_W-1:0] p_s2  [2];
   logic              p_sub [2];

   // Reference model and scoreboard.
   logic [DATA_W:0]   exp_q[$];     // {zero, result} of the outstanding op
   int                exp_gnt, exp_due, mdl_last, cyc;
   logic [DATA_W-1:0] exp_s1, exp_s2;
   logic              exp_sub;
   int                gnt_log[$];
   int                n_checks = 0, n_pass = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   function automatic int mdl_grant(input logic v0, input logic v1);
      if (v0 && v1) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
         return 0;
`else
         return (mdl_last == 0) ? 1 : 0;
`endif
      end
      return v0 ? 0 : 1;
   endfunction

   task automatic set_op(input int r, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                         input logic s);
      p_vld[r] = 1'b1; p_s1[r] = a; p_s2[r] = b; p_sub[r] = s;
   endtask

   task automatic rand_op(input int r);
      logic [DATA_W-1:0] a;
      a = $urandom;
      set_op(r, a, ($urandom_range(0, 3) == 0) ? a : DATA_W'($urandom), 1'($urandom_range(0, 1)));
   endtask

   // One clock cycle: drive inputs at negedge, check 1ns later, then advance the model.
   task automatic tick(input logic [1:0] rr);
      logic [1:0]      exp_rdy, exp_rv;
      logic [DATA_W:0] e;
      int              g;
      @(negedge clk);
      req_valid = {p_vld[1], p_vld[0]};
      req0_src1 = p_s1[0]; req0_src2 = p_s2[0]; req0_sub = p_sub[0];
      req1_src1 = p_s1[1]; req1_src2 = p_s2[1]; req1_sub = p_sub[1];
      rsp_ready = rr;
      #1;
      exp_rdy = 2'b00;
      g = 0;
      if (exp_q.size() == 0 && req_valid != 2'b00) begin
         g = mdl_grant(p_vld[0], p_vld[1]);
         exp_rdy[g] = 1'b1;
      end
      check("req_ready", 64'(req_ready), 64'(exp_rdy));
      check("alu_op", 64'(ALU_Op), 64'd0);
      exp_rv = 2'b00;
      if (exp_q.size() != 0) begin
         check("alu_src1", 64'(alu_src1), 64'(exp_s1));
         check("alu_src2", 64'(alu_src2), 64'(exp_s2));
         check("add_sub_sel", 64'(add_sub_sel), 64'(exp_sub));
         if (cyc >= exp_due) exp_rv[exp_gnt] = 1'b1;
      end
      check("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
      if (exp_rv != 2'b00) begin
         e = exp_q[0];
         check("rsp_result", 64'(rsp_result), 64'(e[DATA_W-1:0]));
         check("rsp_zero", 64'(rsp_zero), 64'(e[DATA_W]));
         if (rr[exp_gnt]) begin
            void'(exp_q.pop_front());
            mdl_last = exp_gnt;
         end
      end
      if (exp_rdy != 2'b00) begin
         exp_s1  = p_s1[g];
         exp_s2  = p_s2[g];
         exp_sub = p_sub[g];
         e[DATA_W-1:0] = exp_sub ? (exp_s1 - exp_s2) : (exp_s1 + exp_s2);
         e[DATA_W]     = (exp_s1 != exp_s2);
         exp_q.push_back(e);
         exp_gnt = g;
         exp_due = cyc + 2;
         gnt_log.push_back(g);
         p_vld[g] = 1'b0;
      end
      cyc++;
   endtask

   // Reset for n cycles, then check every reset value and clear the model.
   task automatic do_reset(input int n);
      @(negedge clk);
      reset = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
      p_vld[0] = 1'b0; p_vld[1] = 1'b0;
      repeat (n) @(negedge clk);
      reset = 1'b0;
      #1;
      exp_q.delete();
      mdl_last = 1;
      check("rst_req_ready", 64'(req_ready), 64'd0);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_rsp_result", 64'(rsp_result), 64'd0);
      check("rst_rsp_zero", 64'(rsp_zero), 64'd0);
      check("rst_alu_src1", 64'(alu_src1), 64'd0);
      check("rst_alu_src2", 64'(alu_src2), 64'd0);
      check("rst_add_sub_sel", 64'(add_sub_sel), 64'd0);
      check("rst_alu_op", 64'(ALU_Op), 64'd0);
      check("rst_state", 64'(dbg_state), 64'd0);
      check("rst_last_grant", 64'(dbg_last_grant), 64'd1);
   endtask

   initial begin
      int exp_seq[4];
      p_vld = '{1'b0, 1'b0}; p_s1 = '{'0, '0}; p_s2 = '{'0, '0}; p_sub = '{1'b0, 1'b0};
      mdl_last = 1; cyc = 0; exp_gnt = 0; exp_due = 0;
      exp_s1 = '0; exp_s2 = '0; exp_sub = 1'b0;

      do_reset(2);

      // Requester 0: 5 + 3.
      set_op(0, 32'd5, 32'd3, 1'b0);
      repeat (3) tick(2'b11);
      check("first_sum_done", 64'(exp_q.size()), 64'd0);

      // Requester 1: 7 - 7, then 0 - 1.
      set_op(1, 32'd7, 32'd7, 1'b1);
      repeat (3) tick(2'b11);
      set_op(1, 32'd0, 32'd1, 1'b1);
      repeat (3) tick(2'b11);
      // Wrap-around add with differing operands.
      set_op(0, 32'hFFFF_FFFF, 32'd1, 1'b0);
      repeat (3) tick(2'b11);

      // Continuous contention after reset: grant order follows policy.
      do_reset(1);
      gnt_log.delete();
      repeat (12) begin
         if (!p_vld[0]) rand_op(0);
         if (!p_vld[1]) rand_op(1);
         tick(2'b11);
      end
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_seq = '{0, 0, 0, 0};
`else
      exp_seq = '{0, 1, 0, 1};
`endif
      check("grant_count", 64'(gnt_log.size()), 64'd4);
      for (int i = 0; i < 4 && i < gnt_log.size(); i++)
         check($sformatf("grant_seq%0d", i), 64'(gnt_log[i]), 64'(exp_seq[i]));

      // Back-pressure: response held 5 cycles with both requesters waiting.
      do_reset(1);
      rand_op(0); rand_op(1);
      tick(2'b11);              // accept
      tick(2'b00);              // EXEC
      repeat (5) tick(2'b00);   // RESP stalled
      tick(2'b11);              // handshake
      tick(2'b11);              // next accept per policy

      // Reset during EXEC.
      do_reset(1);
      rand_op(0);
      tick(2'b11);
      do_reset(1);
      // Reset during RESP after requester 0 was the last served.
      rand_op(0);
      repeat (3) tick(2'b11);
      rand_op(0);
      tick(2'b11);
      tick(2'b11);
      do_reset(1);

      // Random traffic with random response back-pressure.
      repeat (600) begin
         for (int r = 0; r < 2; r++)
            if (!p_vld[r] && $urandom_range(0, 2) != 0) rand_op(r);
         tick(2'($urandom_range(0, 3)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
